// File: rtl/stream_mux_nch_pkg.sv
// Shared constants and helpers for the N:1 registered stream multiplexer.
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int unsigned wrap_inc(
      input int unsigned ptr,
      input int unsigned n
   );
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/stream_mux_nch_if.sv
// Bundle of channel inputs, control and consumer port of the stream mux.
interface stream_mux_nch_if #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
);
   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH*WIDTH-1:0] A_DATA;
   logic [NCH-1:0]       A_VALID;
   logic [NCH-1:0]       A_READY;
   logic [SELW-1:0]      SL;
   logic                 MODE;
   logic [WIDTH-1:0]     Z;
   logic                 Z_VALID;
   logic                 Z_READY;
   logic [SELW-1:0]      Z_CH;

   modport master (
      output A_DATA, A_VALID, SL, MODE, Z_READY,
      input  A_READY, Z, Z_VALID, Z_CH
   );

   modport slave (
      input  A_DATA, A_VALID, SL, MODE, Z_READY,
      output A_READY, Z, Z_VALID, Z_CH
   );

endinterface

// File: rtl/stream_mux_nch_rr_pick.sv
// Rotating-priority encoder: first set request at or after the start index.
module stream_mux_rr_pick #(
   parameter int NCH  = 4,
   parameter int SELW = 2
) (
   input  logic [NCH-1:0]  req_i,
   input  logic [SELW-1:0] start_i,
   output logic            found_o,
   output logic [SELW-1:0] idx_o
);

   int j;

   // Scan from the far end so the nearest request to start_i wins last.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      for (int k = NCH - 1; k >= 0; k--) begin
         j = int'(start_i) + k;
         if (j >= NCH) j = j - NCH;
         if (req_i[j]) begin
            found_o = 1'b1;
            idx_o   = SELW'(j);
         end
      end
   end

endmodule

// File: rtl/stream_mux_nch.sv
// N:1 registered stream mux with fixed-select or round-robin grant.
module stream_mux_nch
   import stream_mux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NCH   = 4
) (
   input logic              CK,
   input logic              R,
   stream_mux_nch_if.slave  io
);

   localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [WIDTH-1:0] z_q, z_d;
   logic             zv_q, zv_d;
   logic [SELW-1:0]  zch_q, zch_d;
   logic [SELW-1:0]  ptr_q, ptr_d;

   logic             ld;
   logic [SELW-1:0]  g;
   logic             gv;
   logic             rr_found;
   logic [SELW-1:0]  rr_idx;
   logic [NCH-1:0]   a_ready;
   logic             xfer;
   logic [WIDTH-1:0] a_sel;

   stream_mux_rr_pick #(
      .NCH  (NCH),
      .SELW (SELW)
   ) u_pick (
      .req_i   (io.A_VALID),
      .start_i (ptr_q),
      .found_o (rr_found),
      .idx_o   (rr_idx)
   );

   always_comb begin
      ld = !zv_q | io.Z_READY;
      g  = '0;
      gv = 1'b0;
      unique case (io.MODE)
         MODE_RR: begin
            g  = rr_idx;
            gv = rr_found;
         end
         default: begin
            g  = io.SL;
            gv = int'(io.SL) < NCH;
         end
      endcase
   end

   // Ready is only ever raised on the granted lane, and never in reset.
   always_comb begin
      a_ready = '0;
      a_sel   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (g == SELW'(i)) begin
            a_ready[i] = !R && gv && ld;
            a_sel      = io.A_DATA[i*WIDTH +: WIDTH];
         end
      end
      xfer = |(io.A_VALID & a_ready);
   end

   always_comb begin
      z_d   = z_q;
      zv_d  = zv_q;
      zch_d = zch_q;
      ptr_d = ptr_q;
      if (xfer) begin
         z_d   = a_sel;
         zv_d  = 1'b1;
         zch_d = g;
         if (io.MODE == MODE_RR)
            ptr_d = SELW'(wrap_inc(32'(g), 32'(NCH)));
      end else if (zv_q && io.Z_READY) begin
         zv_d = 1'b0;
      end
   end

   always_ff @(posedge CK or posedge R) begin
      if (R) begin
         z_q   <= '0;
         zv_q  <= 1'b0;
         zch_q <= '0;
         ptr_q <= '0;
      end else begin
         z_q   <= z_d;
         zv_q  <= zv_d;
         zch_q <= zch_d;
         ptr_q <= ptr_d;
      end
   end

   assign io.A_READY = a_ready;
   assign io.Z       = z_q;
   assign io.Z_VALID = zv_q;
   assign io.Z_CH    = zch_q;

endmodule
